// File: rtl/mem_handshake_responder_pkg.sv
// Shared constants, state encoding and lane helpers for the MFA/MFC memory responder.
// Lane i of the byte array always addresses byte (A + i) mod 2**ADDR_W.
package mem_handshake_responder_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Type 2'b11 is serviced exactly like a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] access_type);
        case (access_type)
            TYPE_BYTE: lane_mask = 4'b0001;
            TYPE_HALF: lane_mask = 4'b0011;
            default:   lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] access_type, input logic [1:0] addr_lo);
        case (access_type)
            TYPE_BYTE: is_misaligned = 1'b0;
            TYPE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage with four wrapped lanes: lane i reads/writes byte (addr + i) mod depth.
// The array is a plain reg so benches can preload it hierarchically.
module mem_byte_array #(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [3:0]             we,
    input  logic [3:0][7:0]        wdata,
    output logic [3:0][7:0]        rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    reg [7:0] Mem [0:DEPTH-1];

    logic [3:0][ADDR_W-1:0] lane_addr;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = addr + ADDR_W'(i);
            rdata[i]     = Mem[lane_addr[i]];
        end
    end

    // NOTE: storage has no reset; contents survive rst and only enabled lanes are written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) Mem[lane_addr[i]] <= wdata[i];
        end
    end

endmodule

// File: rtl/mem_handshake_responder.sv
// Memory-side MFA/MFC responder: latches a request, waits WAIT_CYCLES, performs a
// big-endian byte/halfword/word access on a wrapped 2**ADDR_W array, then holds MFC until MFA drops.
module mem_handshake_responder
    import mem_handshake_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        Type,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Misalign
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             capture, access;

    logic              req_rw;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;

    logic [3:0]      lane_we;
    logic [3:0][7:0] lane_wdata;
    logic [3:0][7:0] lane_rdata;
    logic [31:0]     read_item;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (MFA) begin
                    capture    = 1'b1;
                    state_next = BUSY;
                    cnt_next   = WAIT_INIT;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                if (!MFA) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign MFC = (state == DONE);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            req_rw   <= RW_READ;
            req_type <= TYPE_BYTE;
            req_addr <= '0;
            req_data <= '0;
        end else if (capture) begin
            req_rw   <= RW;
            req_type <= Type;
            req_addr <= Address;
            req_data <= DataIn;
        end
    end

    // Lane 0 is the byte at the request address, i.e. the most significant byte of the item.
    always_comb begin
        lane_wdata = '0;
        read_item  = '0;
        case (req_type)
            TYPE_BYTE: begin
                lane_wdata[0] = req_data[7:0];
                read_item     = {24'b0, lane_rdata[0]};
            end
            TYPE_HALF: begin
                lane_wdata[0] = req_data[15:8];
                lane_wdata[1] = req_data[7:0];
                read_item     = {16'b0, lane_rdata[0], lane_rdata[1]};
            end
            default: begin
                lane_wdata = {req_data[7:0], req_data[15:8], req_data[23:16], req_data[31:24]};
                read_item  = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
            end
        endcase
    end

    assign lane_we = (access && req_rw == RW_WRITE) ? lane_mask(req_type) : 4'b0000;

    mem_byte_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (CLK),
        .addr  (req_addr),
        .we    (lane_we),
        .wdata (lane_wdata),
        .rdata (lane_rdata)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            DataOut  <= '0;
            Misalign <= 1'b0;
        end else if (access) begin
            Misalign <= is_misaligned(req_type, req_addr[1:0]);
            if (req_rw == RW_READ) DataOut <= read_item;
        end
    end

endmodule

// File: tb/tb_mem_handshake_responder.sv
// Bench for mem_handshake_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, each
// checked every cycle against a transaction-level model (byte array + latency formula).
module tb_mem_handshake_responder;

    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        mfa  [2];
    logic        rw   [2];
    logic [1:0]  typ  [2];
    logic [7:0]  addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        mfc  [2];
    logic        mis  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mem_handshake_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut_w2 (
        .CLK(CLK), .Reset(Reset), .MFA(mfa[0]), .RW(rw[0]), .Type(typ[0]),
        .Address(addr[0]), .DataIn(din[0]), .DataOut(dout[0]), .MFC(mfc[0]), .Misalign(mis[0])
    );

    mem_handshake_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .CLK(CLK), .Reset(Reset), .MFA(mfa[1]), .RW(rw[1]), .Type(typ[1]),
        .Address(addr[1]), .DataIn(din[1]), .DataOut(dout[1]), .MFC(mfc[1]), .Misalign(mis[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          wait_of [2] = '{2, 0};
    logic [7:0]  ref_mem [2][DEPTH];
    int          ph      [2] = '{0, 0};   // 0 idle, 1 request pending, 2 complete
    int          cap     [2];
    logic        m_rw    [2];
    logic [1:0]  m_ty    [2];
    logic [7:0]  m_a     [2];
    logic [31:0] m_d     [2];
    logic [31:0] e_dout  [2] = '{32'h0, 32'h0};
    logic        e_mis   [2] = '{1'b0, 1'b0};
    int          edge_no = 0;

    task automatic model_access(input int k);
        int n;
        int a;
        logic [31:0] item;
        n = (m_ty[k] == 2'b00) ? 1 : (m_ty[k] == 2'b01) ? 2 : 4;
        a = int'(m_a[k]);
        e_mis[k] = (n == 4 && a % 4 != 0) || (n == 2 && a % 2 != 0);
        item = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (m_rw[k]) ref_mem[k][(a + i) % DEPTH] = 8'(m_d[k] >> (8 * (n - 1 - i)));
            else item = (item << 8) | 32'(ref_mem[k][(a + i) % DEPTH]);
        end
        if (!m_rw[k]) e_dout[k] = item;
    endtask

    task automatic model_step(input int k);
        if (!Reset) begin
            ph[k] = 0;
            e_dout[k] = 32'h0;
            e_mis[k] = 1'b0;
            return;
        end
        case (ph[k])
            0: if (mfa[k]) begin
                ph[k] = 1; cap[k] = edge_no;
                m_rw[k] = rw[k]; m_ty[k] = typ[k]; m_a[k] = addr[k]; m_d[k] = din[k];
            end
            1: if (edge_no == cap[k] + wait_of[k] + 1) begin
                model_access(k);
                ph[k] = 2;
            end
            default: if (!mfa[k]) ph[k] = 0;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            edge_no++;
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                check($sformatf("mfc[%0d]", k), 32'(mfc[k]), 32'(ph[k] == 2));
                check($sformatf("dout[%0d]", k), dout[k], e_dout[k]);
                check($sformatf("misalign[%0d]", k), 32'(mis[k]), 32'(e_mis[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic scramble(input int k);
        rw[k]   = 1'($urandom);
        typ[k]  = 2'($urandom);
        addr[k] = 8'($urandom);
        din[k]  = $urandom;
    endtask

    // Issues one request, returns edges from capture to MFC rising (-1 on timeout).
    task automatic do_req(input int k, input logic rw_v, input logic [1:0] ty, input logic [7:0] a,
                          input logic [31:0] d, input int hold, input bit early, output int lat);
        int cnt;
        bit seen;
        @(negedge CLK);
        mfa[k] = 1'b1; rw[k] = rw_v; typ[k] = ty; addr[k] = a; din[k] = d;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(posedge CLK);
            cnt++;
            @(negedge CLK);
            if (early && cnt == 1) mfa[k] = 1'b0;
            if (mfc[k]) seen = 1'b1;
            else scramble(k);
        end
        if (!seen) begin
            check($sformatf("mfc_timeout[%0d]", k), 32'(mfc[k]), 32'h1);
            lat = -1;
        end else begin
            lat = cnt - 1;
            for (int h = 0; h < hold; h++) begin
                @(negedge CLK);
                scramble(k);
            end
        end
        mfa[k] = 1'b0;
        @(negedge CLK);
        check($sformatf("mfc_drop[%0d]", k), 32'(mfc[k]), 32'h0);
        scramble(k);
    endtask

    int lat;

    initial begin
        Reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mfa[k] = 1'b0;
            scramble(k);
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (i >= 8'h40 && i <= 8'h43) v = 8'h00;
            if (i >= 8'h20 && i <= 8'h23) v = 8'hAA + 8'(8'h11 * (i - 8'h20));
            u_dut_w2.u_array.Mem[i] <= v;
            u_dut_w0.u_array.Mem[i] <= v;
            ref_mem[0][i] = v;
            ref_mem[1][i] = v;
        end
        repeat (2) @(negedge CLK);
        check("reset_mfc", 32'(mfc[0]), 32'h0);
        check("reset_dout", dout[0], 32'h0);
        check("reset_misalign", 32'(mis[0]), 32'h0);
        Reset = 1'b1;

        // Word round trip at 0x10.
        do_req(0, 1'b1, 2'b10, 8'h10, 32'hE3A01005, 0, 1'b0, lat);
        check("wr_latency", 32'(lat), 32'd3);
        check("mem10", 32'(u_dut_w2.u_array.Mem[8'h10]), 32'hE3);
        check("mem11", 32'(u_dut_w2.u_array.Mem[8'h11]), 32'hA0);
        check("mem12", 32'(u_dut_w2.u_array.Mem[8'h12]), 32'h10);
        check("mem13", 32'(u_dut_w2.u_array.Mem[8'h13]), 32'h05);
        do_req(0, 1'b0, 2'b10, 8'h10, 32'h0, 0, 1'b0, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_word", dout[0], 32'hE3A01005);

        // Byte and halfword reads.
        do_req(0, 1'b0, 2'b00, 8'h21, 32'h0, 1, 1'b0, lat);
        check("rd_byte", dout[0], 32'h000000BB);
        check("rd_byte_mis", 32'(mis[0]), 32'h0);
        do_req(0, 1'b0, 2'b01, 8'h22, 32'h0, 0, 1'b0, lat);
        check("rd_half", dout[0], 32'h0000CCDD);
        check("rd_half_mis", 32'(mis[0]), 32'h0);

        // Wrapping, misaligned word write; DataOut keeps the last read value.
        do_req(0, 1'b1, 2'b10, 8'hFE, 32'h11223344, 0, 1'b0, lat);
        check("wrap_memFE", 32'(u_dut_w2.u_array.Mem[8'hFE]), 32'h11);
        check("wrap_memFF", 32'(u_dut_w2.u_array.Mem[8'hFF]), 32'h22);
        check("wrap_mem00", 32'(u_dut_w2.u_array.Mem[8'h00]), 32'h33);
        check("wrap_mem01", 32'(u_dut_w2.u_array.Mem[8'h01]), 32'h44);
        check("wrap_mis", 32'(mis[0]), 32'h1);
        check("wrap_dout_kept", dout[0], 32'h0000CCDD);

        // MFA held five cycles past MFC with changing inputs: exactly one write.
        do_req(0, 1'b1, 2'b10, 8'h30, 32'hCAFEF00D, 5, 1'b0, lat);
        check("hold_mem30", 32'(u_dut_w2.u_array.Mem[8'h30]), 32'hCA);
        check("hold_mem33", 32'(u_dut_w2.u_array.Mem[8'h33]), 32'h0D);

        // MFA dropped during BUSY: access completes, MFC pulses once.
        do_req(0, 1'b0, 2'b10, 8'h30, 32'h0, 0, 1'b1, lat);
        check("early_latency", 32'(lat), 32'd3);
        check("early_dout", dout[0], 32'hCAFEF00D);

        // Reset during BUSY aborts the write.
        @(negedge CLK);
        mfa[0] = 1'b1; rw[0] = 1'b1; typ[0] = 2'b10; addr[0] = 8'h40; din[0] = 32'hFFFFFFFF;
        @(negedge CLK);
        #2 Reset = 1'b0;
        #1 check("busy_reset_mfc", 32'(mfc[0]), 32'h0);
        mfa[0] = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++)
            check($sformatf("abort_mem%0h", 8'h40 + i), 32'(u_dut_w2.u_array.Mem[8'h40 + i]), 32'h0);
        do_req(0, 1'b0, 2'b10, 8'h40, 32'h0, 0, 1'b0, lat);
        check("post_reset_latency", 32'(lat), 32'd3);
        check("post_reset_dout", dout[0], 32'h0);

        // Reset during DONE drops MFC and DataOut at once.
        do_req(0, 1'b0, 2'b10, 8'h10, 32'h0, 0, 1'b0, lat);
        @(negedge CLK);
        mfa[0] = 1'b1; rw[0] = 1'b0; typ[0] = 2'b10; addr[0] = 8'h10;
        repeat (4) @(negedge CLK);
        check("done_mfc_before_reset", 32'(mfc[0]), 32'h1);
        #2 Reset = 1'b0;
        #1 check("done_reset_mfc", 32'(mfc[0]), 32'h0);
        check("done_reset_dout", dout[0], 32'h0);
        mfa[0] = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;

        // Zero-wait instance.
        do_req(1, 1'b0, 2'b01, 8'h22, 32'h0, 0, 1'b0, lat);
        check("w0_latency", 32'(lat), 32'd1);
        check("w0_half", dout[1], 32'h0000CCDD);
        do_req(1, 1'b1, 2'b01, 8'hFF, 32'h0000BEEF, 0, 1'b0, lat);
        check("w0_wrap_memFF", 32'(u_dut_w0.u_array.Mem[8'hFF]), 32'hBE);
        check("w0_wrap_mem00", 32'(u_dut_w0.u_array.Mem[8'h00]), 32'hEF);
        check("w0_wrap_mis", 32'(mis[1]), 32'h1);

        // Randomized traffic on both instances.
        for (int t = 0; t < 120; t++) begin
            int k;
            k = int'($urandom_range(0, 1));
            do_req(k, 1'($urandom), 2'($urandom), 8'($urandom), $urandom,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), lat);
            check($sformatf("rand_latency[%0d]", k), 32'(lat), 32'(wait_of[k] + 1));
        end

        repeat (2) @(negedge CLK);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("final_w2_mem%0h", i), 32'(u_dut_w2.u_array.Mem[i]), 32'(ref_mem[0][i]));
            check($sformatf("final_w0_mem%0h", i), 32'(u_dut_w0.u_array.Mem[i]), 32'(ref_mem[1][i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_handshake_responder.md
Name: mem_handshake_responder

Overview:
- Memory-side responder for the processor's MFA/MFC memory handshake.
- The control unit/datapath raises MFA with address, RW and access type, then waits for MFC. This block services the request from a 256-byte big-endian array after a programmable wait, asserts MFC, and holds it until MFA drops.
- It replaces a zero-latency RAM so the control unit's MFC wait states are exercised.

Parameters:
- ADDR_W, 8, byte-address width; array depth is 2**ADDR_W bytes.
- WAIT_CYCLES, 2, cycles spent in BUSY before completion; legal range 0..15.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- MFA  input  1  memory function activate; request valid, held high by the initiator until MFC is seen.
- RW  input  1  1 = write, 0 = read.
- Type  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- Address  input  ADDR_W  byte address.
- DataIn  input  32  write data, right-justified.
- DataOut  output  32  read data, right-justified and zero-extended.
- MFC  output  1  memory function complete.
- Misalign  output  1  completed request was unaligned for its Type.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE, MFC=0, DataOut=0, Misalign=0, wait counter 0. Array contents are not cleared.
- IDLE:
  - On a rising CLK with MFA=1, latch RW, Type, Address and DataIn.
  - Go to BUSY with counter=WAIT_CYCLES. If WAIT_CYCLES=0, go directly to the access cycle.
  - Inputs are ignored after latching.
- BUSY: decrement the counter each cycle. When the counter reaches 0, perform the access on that edge and go to DONE.
- Access:
  - Byte order is big-endian: byte at A is the MSB of the item.
  - Word covers A..A+3; halfword covers A..A+1; byte covers A only.
  - Address arithmetic wraps modulo 2**ADDR_W (e.g. word at 8'hFE uses FE, FF, 00, 01).
  - Read: DataOut gets the item zero-extended; upper bits are 0 for byte and halfword.
  - Write: store the low 8, 16 or 32 bits of the latched DataIn. DataOut is unchanged.
  - Misalign=1 when a word has A[1:0]!=0 or a halfword has A[0]!=0. The access is still performed using the wrap rules.
- DONE:
  - MFC=1 and DataOut/Misalign are held stable.
  - When MFA is sampled low, go to IDLE and drop MFC=0 on that same edge.
  - DataOut keeps its value until the next read completes.
- Latency: MFA sampled high at edge N gives MFC high after edge N+WAIT_CYCLES+1. With WAIT_CYCLES=2, MFC rises 3 edges after request capture.
- Back-to-back requests:
  - MFA must drop for at least one sampled edge between requests.
  - An MFA still high while in DONE never starts a second access.
- MFA dropping during BUSY (protocol violation): the access still completes. MFC pulses high for one cycle, then the block returns to IDLE.
- Reset asserted in BUSY aborts the access. No array byte is modified, and MFC goes 0 immediately.
- Backdoor preload: the array is a plain reg [7:0] Mem[0:2**ADDR_W-1] so benches can load bytes hierarchically, as the current fill loop does.

Decomposition:
- Shared package constants:
  - TYPE_BYTE=2'b00, TYPE_HALF=2'b01, TYPE_WORD=2'b10.
  - RW_READ=1'b0, RW_WRITE=1'b1.
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
- One natural sub-module: mem_byte_array. It holds the byte storage with a 4-lane write enable and four wrapped read ports. The responder owns the FSM, counter, lane/enable generation and alignment check.

Test Plan:
- Word write/read round trip. Write 32'hE3A01005 at address 8'h10 (RW=1, Type=10), then read back. Required: Mem[10..13]=E3,A0,10,05; read DataOut=32'hE3A01005; MFC rises exactly 3 edges after MFA is captured (WAIT_CYCLES=2).
- Byte and halfword reads. Mem[20..23]=AA,BB,CC,DD. Byte read at 8'h21 gives 32'h000000BB. Halfword read at 8'h22 gives 32'h0000CCDD. Misalign=0 for both.
- Wrap and misalign. Word write 32'h11223344 at 8'hFE. Required: Mem[FE]=11, Mem[FF]=22, Mem[00]=33, Mem[01]=44; Misalign=1.
- Handshake hold. Keep MFA high 5 cycles past MFC. Required: MFC and DataOut stable, only one access performed; MFC=0 on the edge MFA is sampled low.
- Reset mid-access. Start a word write of 32'hFFFFFFFF to 8'h40 (prior contents 0), assert Reset low during BUSY. Required: MFC=0 immediately; Mem[40..43] still 0; next request behaves normally.
- WAIT_CYCLES=0 instance. A read completes with MFC high after the edge following capture; DataOut is correct on that cycle.
